// File: rtl/memory_sequencer.sv
// Acquisition sequencer: fills a circular sample memory while dav is offered, then replays it FIFO.
// Optional MEMSEQ_OVERWRITE_EN: writes while Full overwrite the oldest sample instead of stopping.
module memory_sequencer #(
    parameter int unsigned ADDR_W       = 4,
    parameter logic [7:0]  WRITE_WINDOW = 8'd10,
    parameter logic [7:0]  READ_HOLD    = 8'd2
) (
    input  logic              clock1Hz,
    input  logic              reset,
    input  logic              start,
    input  logic              dav,
    output logic              ack,
    output logic              WriteEnable,
    output logic              MemoryEnable,
    output logic [ADDR_W-1:0] Address,
    output logic              ReadValid,
    output logic [ADDR_W:0]   Count,
    output logic              Full,
    output logic              Empty,
    output logic [1:0]        PresentStateFlag
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StRead  = 2'd2,
        StRsvd  = 2'd3
    } state_e;

    localparam logic [ADDR_W:0] Depth    = {1'b1, {ADDR_W{1'b0}}};
    // A zero-length window or hold behaves as a single cycle.
    localparam logic [7:0]      WinLast  = (WRITE_WINDOW == 8'd0) ? 8'd0 : WRITE_WINDOW - 8'd1;
    localparam logic [7:0]      HoldLast = (READ_HOLD == 8'd0) ? 8'd0 : READ_HOLD - 8'd1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        timer_q, timer_d;
    logic [7:0]        hold_q, hold_d;
    logic              full;
    logic              accept;
    logic              write_done;

    assign full             = (count_q == Depth);
    assign Full             = full;
    assign Empty            = (count_q == '0);
    assign Count            = count_q;
    assign PresentStateFlag = state_q;

    always_ff @(posedge clock1Hz or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            timer_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            timer_q  <= timer_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        timer_d      = '0;
        hold_d       = '0;
        accept       = 1'b0;
        write_done   = 1'b0;
        ack          = 1'b0;
        WriteEnable  = 1'b0;
        MemoryEnable = 1'b0;
        ReadValid    = 1'b0;
        Address      = wr_ptr_q;

        unique case (state_q)
            StIdle: begin
                if (start) state_d = StWrite;
            end
            StWrite: begin
                MemoryEnable = 1'b1;
                timer_d      = timer_q + 8'd1;
`ifdef MEMSEQ_OVERWRITE_EN
                accept = dav;
`else
                accept = dav & ~full;
`endif
                ack         = accept;
                WriteEnable = accept;
                if (accept) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    // Only reachable with overwrite: the oldest sample is dropped.
                    if (full) rd_ptr_d = rd_ptr_q + 1'b1;
                    else      count_d  = count_q + 1'b1;
                end
`ifdef MEMSEQ_OVERWRITE_EN
                write_done = (timer_q == WinLast);
`else
                write_done = (timer_q == WinLast) || (count_d == Depth);
`endif
                if (write_done) state_d = (count_d != '0) ? StRead : StIdle;
            end
            StRead: begin
                MemoryEnable = 1'b1;
                Address      = rd_ptr_q;
                timer_d      = timer_q + 8'd1;
                if (hold_q == HoldLast) begin
                    ReadValid = 1'b1;
                    rd_ptr_d  = rd_ptr_q + 1'b1;
                    count_d   = count_q - 1'b1;
                    if (count_d == '0) state_d = StIdle;
                end else begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) timer_d = '0;
    end

endmodule

// File: doc/memory_sequencer.md
MEMORY_SEQUENCER -- requirements
Module: memory_sequencer

Interface
REQ-001 Parameter ADDR_W, default 4, address width; memory depth = 2**ADDR_W.
REQ-002 Parameter WRITE_WINDOW, default 8'd10, cycles spent in Write per acquisition run.
REQ-003 Parameter READ_HOLD, default 8'd2, cycles each address is held in Read.
REQ-004 clock1Hz  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level; requests a new acquisition run while Idle.
REQ-007 dav  input  1  data-available from source; one sample offered per cycle high.
REQ-008 ack  output  1  sample accepted this cycle.
REQ-009 WriteEnable  output  1  memory write strobe.
REQ-010 MemoryEnable  output  1  memory chip enable.
REQ-011 Address  output  ADDR_W  memory address.
REQ-012 ReadValid  output  1  memory read data at Address is to be consumed this cycle.
REQ-013 Count  output  ADDR_W+1  samples stored, 0..2**ADDR_W.
REQ-014 Full, Empty  output  1 each  Count==2**ADDR_W / Count==0.
REQ-015 PresentStateFlag  output  2  current state encoding.

Function
REQ-016 States SHALL be Idle=2'd0, Write=2'd1, Read=2'd2; 2'd3 SHALL be treated as Idle, with next state Idle.
REQ-017 Idle: MemoryEnable=0, WriteEnable=0, ack=0, ReadValid=0, Address=wr_ptr; start=1 -> Write next cycle, timer cleared.
REQ-018 Write: MemoryEnable=1, Address=wr_ptr; WriteEnable=ack=dav&~Full, combinational, same cycle as dav.
REQ-019 On each accepted write: wr_ptr+1 mod 2**ADDR_W, Count+1 at the following edge.
REQ-020 Internal 8-bit timer SHALL increment every cycle in Write and Read and clear on every state change.
REQ-021 Write exits when timer==WRITE_WINDOW-1 or Count becomes Full: -> Read if Count (after this cycle's write) >0, else -> Idle.
REQ-022 A write accepted in the exit cycle SHALL be stored and counted.
REQ-023 Read: MemoryEnable=1, WriteEnable=0, ack=0, Address=rd_ptr; ReadValid=1 only in the last cycle of each hold (hold counter==READ_HOLD-1).
REQ-024 At the end of each hold: rd_ptr+1 mod 2**ADDR_W, Count-1, hold counter cleared; Count reaching 0 -> Idle.
REQ-025 dav in Idle or Read SHALL be ignored (ack=0, no pointer change); start outside Idle SHALL be ignored.
REQ-026 Pointers SHALL persist across runs, so data order is FIFO across wrap-around.
REQ-027 READ_HOLD=0 or WRITE_WINDOW=0 SHALL behave as 1.

Reset
REQ-028 reset SHALL force, asynchronously, state=Idle, wr_ptr=rd_ptr=0, Count=0, timer=0, hold counter=0.
REQ-029 While reset is high, outputs SHALL be: WriteEnable=MemoryEnable=ack=ReadValid=0, Address=0, Count=0, Empty=1, Full=0, PresentStateFlag=0.
REQ-030 Reset mid-Write or mid-Read SHALL discard all stored samples; the first edge after release SHALL evaluate from Idle.

Configuration
REQ-031 Macro MEMSEQ_OVERWRITE_EN: when defined, dav in Write while Full SHALL be accepted (ack=WriteEnable=1), overwriting the oldest sample; wr_ptr and rd_ptr both advance and Count stays Full.
REQ-032 Without MEMSEQ_OVERWRITE_EN, dav while Full SHALL be refused (ack=0) and Full terminates Write per REQ-021.
REQ-033 With the macro defined, Full SHALL NOT terminate Write; only the timer does.

Verification
REQ-034 Reset, start=1 one cycle, dav=1 for 3 cycles -> ack on those 3 cycles; Read after 10 Write cycles; addresses 0,1,2 each held 2 cycles with ReadValid on the 2nd; Idle with Count=0.
REQ-035 dav held high through 20-cycle Write window (ADDR_W=4, WRITE_WINDOW=20), macro off -> 16 acks, Full=1, Read entered directly after the 16th write.
REQ-036 Same stimulus, macro on -> 20 acks; Read starts at rd_ptr=4 and returns the last 16 samples in order.
REQ-037 start with dav=0 throughout -> Write for 10 cycles, then Idle without entering Read; Count stays 0.
REQ-038 Assert reset during Read with Count=5 -> immediate Idle, Count=0, Empty=1, all strobes low; next run writes from Address 0.
REQ-039 Two runs of 10 samples each (ADDR_W=4) -> second run's addresses wrap 10..15,0..3 and read back in the same order.
